// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and the bit layout of SR/Cause.
package cp0_defs;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam int IM_HI  = 15;
  localparam int IM_LO  = 10;
  localparam int EXL    = 1;
  localparam int IE     = 0;
  localparam int BD     = 31;
  localparam int EXC_HI = 6;
  localparam int EXC_LO = 2;

endpackage

// File: rtl/cp0_unit.sv
// M-stage coprocessor 0: SR/Cause/EPC/PRId storage, interrupt vs exception arbitration, mfc0 read port.
// req is a same-cycle, single-cycle pulse with no handshake: when high, the pipeline must flush and
// this edge commits the exception state; the M-stage instruction's own mtc0/eret is dropped.
module cp0_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2022_0007,
  parameter int          HW_INT_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [4:0]          cp0_addr,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         cp0_rdata,
  input  logic [31:0]         vpc,
  input  logic                bd_in,
  input  logic [4:0]          exc_code_in,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                eret,
  output logic                req,
  output logic [31:0]         epc_out
);

  logic [HW_INT_W-1:0] sr_im;
  logic                sr_exl;
  logic                sr_ie;
  logic                cause_bd;
  logic [HW_INT_W-1:0] cause_ip;
  logic [4:0]          cause_exc;
  logic [31:0]         epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_next;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        unused_wdata;

  assign unused_wdata = ^{cp0_wdata[31:IM_HI+1], cp0_wdata[IM_LO-1:EXL+1]};

  assign int_req  = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req  = (exc_code_in != 5'd0) & ~sr_exl;
  assign req      = ~reset & (int_req | exc_req);

  // A delay-slot victim restarts at its branch; word-align the resume PC.
  assign epc_next = (bd_in ? (vpc - 32'd4) : vpc) & ~32'h3;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd_in;
        cause_exc <= int_req ? EXC_INT : exc_code_in;
        epc       <= epc_next;
      end else begin
        if (we && cp0_addr == ADDR_SR) begin
          sr_im  <= cp0_wdata[IM_HI:IM_LO];
          sr_exl <= cp0_wdata[EXL];
          sr_ie  <= cp0_wdata[IE];
        end
        if (we && cp0_addr == ADDR_EPC) begin
          epc <= cp0_wdata;
        end
        // Placed last so eret's EXL clear overrides a coincident SR write.
        if (eret) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sr_word                 = 32'd0;
    sr_word[IM_HI:IM_LO]    = sr_im;
    sr_word[EXL]            = sr_exl;
    sr_word[IE]             = sr_ie;
    cause_word              = 32'd0;
    cause_word[BD]          = cause_bd;
    cause_word[IM_HI:IM_LO] = cause_ip;
    cause_word[EXC_HI:EXC_LO] = cause_exc;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = sr_word;
      ADDR_CAUSE: cp0_rdata = cause_word;
      ADDR_EPC:   cp0_rdata = epc;
      ADDR_PRID:  cp0_rdata = PRID_VALUE;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out = epc;

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- M-stage coprocessor 0 for the P7 MIPS pipeline. It holds the SR, Cause, EPC and PRId registers.
- It arbitrates hardware interrupts against synchronous exceptions carried down the pipeline.
- It drives req, which flushes the pipeline registers, including the M/W register.
- It supplies the mfc0 read data that travels to W as CP0Out_M, and the EPC value used for eret.

Parameters:
- PRID_VALUE, 32'h2022_0007, constant returned for register 15.
- HW_INT_W, 6, number of hardware interrupt lines, mapped to IP/IM bits [15:10].

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- we  input  1  mtc0 write enable (M-stage instruction is mtc0)
- cp0_addr  input  5  rd field of the mtc0/mfc0 instruction
- cp0_wdata  input  32  mtc0 write data (forwarded rt)
- cp0_rdata  output  32  mfc0 read data (becomes CP0Out_M)
- vpc  input  32  PC of the M-stage instruction (or the bubble's recorded PC)
- bd_in  input  1  M-stage instruction is in a branch delay slot
- exc_code_in  input  5  pipelined exception code; 0 means none
- hw_int  input  HW_INT_W  external interrupt lines (timer0, timer1, interrupt generator, spare)
- eret  input  1  M-stage instruction is eret
- req  output  1  exception/interrupt taken this cycle
- epc_out  output  32  current EPC, drives the F-stage PC on eret

Behaviour:
- Storage and reset values:
  - SR: IM[15:10], EXL[1], IE[0] stored; all other bits read 0. Reset value 0.
  - Cause: BD[31], IP[15:10], ExcCode[6:2] stored; all other bits read 0. Reset value 0.
  - EPC: full 32 bits. Reset value 0.
- Outputs at reset: req=0, cp0_rdata=0 (addr 0 unimplemented), epc_out=0.
- Request logic (combinational, same cycle):
  - int_req = (|(hw_int & SR.IM)) & SR.IE & !SR.EXL.
  - exc_req = (exc_code_in != 0) & !SR.EXL.
  - req = int_req | exc_req.
  - Interrupt has priority over exception.
  - While reset is high, req is forced to 0.
- On posedge when req=1 and reset=0:
  - SR.EXL <= 1.
  - Cause.BD <= bd_in.
  - Cause.ExcCode <= int_req ? 5'd0 : exc_code_in.
  - EPC <= (bd_in ? vpc - 32'd4 : vpc) & ~32'h3. Arithmetic is 32-bit and wraps modulo 2^32.
- Cause.IP <= hw_int every cycle, unconditionally except during reset. The write happens whatever the state of req, we and eret. mtc0 never writes IP.
- eret on posedge (req=0): SR.EXL <= 0. All other fields are unchanged.
- mtc0 on posedge when we=1 and req=0:
  - addr 12: writes IM, EXL and IE from the corresponding wdata bits.
  - addr 14: writes EPC <= wdata.
  - addr 13 and 15: writes are ignored.
  - Other addresses: no effect.
- Priority for simultaneous events: reset > req > eret > mtc0.
  - An instruction that causes req does not commit its own mtc0 or eret.
  - eret and an mtc0 to SR cannot coincide (single M-stage instruction); if both are asserted, eret's EXL clear wins and the IM/IE bits are still written.
- Read data (combinational):
  - addr 12 returns SR.
  - addr 13 returns Cause.
  - addr 14 returns EPC.
  - addr 15 returns PRID_VALUE.
  - All other addresses return 0.
  - Reads return pre-edge register values; there is no write-to-read bypass.
- epc_out = EPC register (pre-edge).
  - Hazard logic must stall eret in D while an mtc0 to EPC is in E/M.
- With EXL=1, neither interrupts nor exceptions are accepted: req=0 and state is held. Nested exceptions are unsupported by design.
- A held interrupt line re-triggers req on the first cycle after eret clears EXL, if IE=1 and IM matches.
- Reset mid-operation (EXL=1) returns every field to 0 on that edge.

Decomposition:
- Shared package cp0_defs holds:
  - Register addresses: SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12.
  - Field bit positions: IM_HI=15, IM_LO=10, EXL=1, IE=0, BD=31, EXC_HI=6, EXC_LO=2.
- Single module; no sub-module is natural.
- The M/W register consumes cp0_rdata as CP0Out_M and req as its flush input.

Test Plan:
- Reset, then mfc0 of each address -> SR=0, Cause=0, EPC=0, PRId=32'h2022_0007; req=0.
- mtc0 SR=32'h0000_0401, hw_int=6'b000001, vpc=32'h0000_3010, bd_in=0 -> req=1 that cycle. After the edge: EXL=1, ExcCode=0, EPC=32'h0000_3010, SR reads 32'h0000_0403.
- exc_code_in=12 (Ov), vpc=32'h0000_3024, bd_in=1, EXL=0 -> req=1. After the edge: Cause.BD=1, ExcCode=12, EPC=32'h0000_3020.
- EXL=1, exc_code_in=10, hw_int=6'h3F -> req=0, EPC unchanged, Cause.IP=6'h3F. Then eret -> EXL=0, and the next cycle req=1 (interrupt re-triggers with IE=1, IM bit 10 set).
- Same cycle: we=1, addr=14, wdata=32'h0000_4000, plus exc_code_in=4 -> EPC=vpc (exception wins), not 32'h0000_4000.
- EXL=1, EPC=32'h0000_3010, reset asserted for one cycle -> SR, Cause and EPC all 0; req stays 0 during reset.
